// File: rtl/ws_pixel_feeder_pkg.sv
// Shared types and PIO action codes for the WS2812 pixel feeder.
package ws_pkg;

   localparam logic [5:0] ACT_NOP   = 6'd0;
   localparam logic [5:0] ACT_INSTR = 6'd1;
   localparam logic [5:0] ACT_PUSH  = 6'd4;

   typedef logic [23:0] pixel_t;  // {G,R,B}

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_PUSH,
      S_GAP,
      S_LATCH,
      S_DONE
   } state_t;

endpackage

// File: rtl/ws_pixel_feeder_if.sv
// PIO push bus: the feeder drives action/din/mindex, the PIO returns TX-full.
interface ws_pixel_feeder_if;
   logic [5:0]  action;
   logic [31:0] din;
   logic [1:0]  mindex;
   logic        tx_full;

   modport master (output action, output din, output mindex, input tx_full);
   modport slave  (input action, input din, input mindex, output tx_full);
endinterface

// File: rtl/ws_pixel_feeder_ram.sv
// Frame buffer: one write port, one synchronous read-first read port.
module ws_pixel_ram
   import ws_pkg::*;
#(
   parameter int NPIX = 16,
   parameter int AW   = $clog2(NPIX)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  pixel_t        wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output pixel_t        rd_data
);

   pixel_t mem [NPIX];

   // Same-address write and read in one cycle returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/ws_pixel_feeder.sv
// Streams a frame of GRB pixels into a PIO TX FIFO, then idles out the
// WS2812 latch gap and pulses frame_done.
module ws_pixel_feeder
   import ws_pkg::*;
#(
   parameter int NPIX         = 16,
   parameter int LATCH_CYCLES = 5000,
   parameter int SM_INDEX     = 0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [$clog2(NPIX)-1:0] wr_addr,
   input  pixel_t                  wr_data,
   input  logic                    start,
   ws_pixel_feeder_if.master       pio,
   output logic                    busy,
   output logic                    frame_done,
   output logic [7:0]              stall_cnt
);

   localparam int AW = $clog2(NPIX);
   localparam int IW = AW + 1;
   localparam int CW = $clog2(LATCH_CYCLES + 1);

   state_t        state;
   logic [IW-1:0] idx;
   logic [CW-1:0] lcnt;
   logic [5:0]    action_q;
   logic [31:0]   din_q;
   pixel_t        rd_data;

   ws_pixel_ram #(.NPIX(NPIX), .AW(AW)) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (state == S_READ),
      .rd_addr (idx[AW-1:0]),
      .rd_data (rd_data)
   );

   assign pio.action = action_q;
   assign pio.din    = din_q;
   assign pio.mindex = 2'(SM_INDEX);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         lcnt       <= '0;
         action_q   <= ACT_NOP;
         din_q      <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               stall_cnt <= '0;
               idx       <= '0;
               busy      <= 1'b1;
               state     <= S_READ;
            end
            S_READ: state <= S_PUSH;
            S_PUSH: begin
               if (!pio.tx_full) begin
                  action_q <= ACT_PUSH;
                  din_q    <= {rd_data, 8'h00};
                  idx      <= idx + IW'(1);
                  state    <= S_GAP;
               end else if (stall_cnt != 8'hFF) begin
                  stall_cnt <= stall_cnt + 8'd1;
               end
            end
            // One idle cycle lets tx_full catch up with the push just made.
            S_GAP: begin
               action_q <= ACT_NOP;
               if (idx == IW'(NPIX)) begin
                  lcnt  <= '0;
                  state <= S_LATCH;
               end else begin
                  state <= S_READ;
               end
            end
            S_LATCH: begin
               if (lcnt == CW'(LATCH_CYCLES - 1)) begin
                  frame_done <= 1'b1;
                  busy       <= 1'b0;
                  state      <= S_DONE;
               end else begin
                  lcnt <= lcnt + CW'(1);
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ws_pixel_feeder.sv
// Randomized self-checking bench for ws_pixel_feeder against a cycle-arithmetic model.
module tb_ws_pixel_feeder;

   localparam int NPIX = 16;
   localparam int LAT  = 20;
   localparam int W    = 1024;

   logic        clk = 1'b0;
   logic        reset, wr_en, start, tx_full;
   logic [3:0]  wr_addr;
   logic [23:0] wr_data;
   logic        busy, frame_done;
   logic [7:0]  stall_cnt;

   ws_pixel_feeder_if bus ();
   assign bus.tx_full = tx_full;

   ws_pixel_feeder #(.NPIX(NPIX), .LATCH_CYCLES(LAT), .SM_INDEX(0)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .pio        (bus.master),
      .busy       (busy),
      .frame_done (frame_done),
      .stall_cnt  (stall_cnt)
   );

   always #20 clk = ~clk;

   int checks = 0, errors = 0;
   logic [23:0] pix_model [NPIX];
   bit          full_map [W];
   logic [5:0]  act_tr [W];
   logic [31:0] din_tr [W];
   bit          busy_tr [W], done_tr [W];
   logic [7:0]  stall_tr [W];
   int          pq[$], doneq[$];
   logic [31:0] dq[$];
   int          b2b, bad_act;
   int          mpc [NPIX];
   int          mdone, mstall;

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic write_pix(input logic [3:0] a, input logic [23:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
      pix_model[a] = d;
   endtask

   task automatic clear_map();
      for (int i = 0; i < W; i++) full_map[i] = 1'b0;
   endtask

   // Cycle 0 is the first cycle of the window; start is raised in it.
   task automatic run_frame(input int ncyc, input int hold_until, input int pulse_rel,
                            input int rst_rel, input int wr_rel,
                            input logic [3:0] wa, input logic [23:0] wd);
      for (int r = 0; r < ncyc; r++) begin
         if (r > 0) begin @(posedge clk); #1; end
         act_tr[r] = bus.action; din_tr[r] = bus.din;
         busy_tr[r] = busy; done_tr[r] = frame_done; stall_tr[r] = stall_cnt;
         if (r == ncyc - 1) begin
            start = 1'b0; tx_full = 1'b0; reset = 1'b0; wr_en = 1'b0;
         end else begin
            start   = (r <= hold_until) || (r == pulse_rel);
            tx_full = full_map[r];
            reset   = (r == rst_rel);
            wr_en   = (r == wr_rel);
            wr_addr = wa;
            wr_data = wd;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic gather(input int lo, input int hi);
      pq.delete(); dq.delete(); doneq.delete(); b2b = 0; bad_act = 0;
      for (int r = lo; r <= hi; r++) begin
         if (act_tr[r] == 6'd4) begin pq.push_back(r); dq.push_back(din_tr[r]); end
         if (act_tr[r] != 6'd4 && act_tr[r] != 6'd0) bad_act++;
         if (r > lo && act_tr[r] == 6'd4 && act_tr[r-1] == 6'd4) b2b++;
         if (done_tr[r]) doneq.push_back(r);
      end
   endtask

   // Pixel k's push lands at 3+3k after start plus every stalled decision so far.
   task automatic model_frame(input int t0);
      int stalls = 0;
      for (int k = 0; k < NPIX; k++) begin
         int d = t0 + 2 + 3 * k + stalls;
         while (d < W && full_map[d]) begin stalls++; d++; end
         mpc[k] = d + 1;
      end
      mdone  = mpc[NPIX-1] + 1 + LAT;
      mstall = (stalls > 255) ? 255 : stalls;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.action !== 6'd0) begin
            errors++; $display("FAIL reset_no_push cyc%0d: action=%0d want 0", i, bus.action);
         end
      end
      checks++;
      if (bus.din !== 32'd0 || bus.mindex !== 2'd0 || busy !== 1'b0 ||
          frame_done !== 1'b0 || stall_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: din=%h mindex=%0d busy=%b done=%b stall=%0d want 0/0/0/0/0",
                  bus.din, bus.mindex, busy, frame_done, stall_cnt);
      end
      reset = 1'b0; start = 1'b0;
      idle(2);
   endtask

   task automatic test_full_frame();
      for (int i = 0; i < NPIX; i++) write_pix(4'(i), 24'(24'h010203 * i));
      clear_map();
      model_frame(0);
      run_frame(75, 0, -1, -1, -1, 4'd0, 24'd0);
      gather(0, 74);
      checks++;
      if (pq.size() != NPIX) begin
         errors++; $display("FAIL full_count: pushes=%0d want %0d", pq.size(), NPIX);
      end else begin
         for (int k = 0; k < NPIX; k++) begin
            checks++;
            if (pq[k] != 3 + 3 * k || dq[k] !== {pix_model[k], 8'h00}) begin
               errors++;
               $display("FAIL full_push%0d: cyc=%0d din=%h want cyc=%0d din=%h",
                        k, pq[k], dq[k], 3 + 3 * k, {pix_model[k], 8'h00});
            end
         end
      end
      checks++;
      if (doneq.size() != 1 || doneq[0] != 69 || stall_tr[69] !== 8'd0) begin
         errors++;
         $display("FAIL full_done: ndone=%0d cyc=%0d stall=%0d want 1/69/0",
                  doneq.size(), (doneq.size() > 0) ? doneq[0] : -1, stall_tr[69]);
      end
      checks++;
      if (busy_tr[0] !== 1'b0 || busy_tr[1] !== 1'b1 || busy_tr[68] !== 1'b1 || busy_tr[69] !== 1'b0) begin
         errors++;
         $display("FAIL full_busy: c0=%b c1=%b c68=%b c69=%b want 0110",
                  busy_tr[0], busy_tr[1], busy_tr[68], busy_tr[69]);
      end
      checks++;
      if (b2b != 0 || bad_act != 0) begin
         errors++; $display("FAIL full_action_codes: b2b=%0d bad=%0d want 0/0", b2b, bad_act);
      end
   endtask

   task automatic test_backpressure();
      int quiet = 0;
      clear_map();
      for (int c = 5; c <= 14; c++) full_map[c] = 1'b1;
      model_frame(0);
      run_frame(85, 0, -1, -1, -1, 4'd0, 24'd0);
      gather(0, 84);
      for (int c = 5; c <= 15; c++) if (act_tr[c] == 6'd4) quiet++;
      checks++;
      if (quiet != 0) begin
         errors++; $display("FAIL bp_quiet: pushes in 5..15=%0d want 0", quiet);
      end
      checks++;
      if (pq.size() != NPIX || pq[1] != 16 || dq[1] !== {pix_model[1], 8'h00} || mpc[1] != 16) begin
         errors++; $display("FAIL bp_pix1: n=%0d cyc=%0d want n=16 cyc=16", pq.size(),
                            (pq.size() > 1) ? pq[1] : -1);
      end
      checks++;
      if (doneq.size() != 1 || doneq[0] != 79 || stall_tr[79] !== 8'd10) begin
         errors++; $display("FAIL bp_done: cyc=%0d stall=%0d want 79/10",
                            (doneq.size() > 0) ? doneq[0] : -1, stall_tr[79]);
      end
   endtask

   task automatic test_stall_saturate();
      clear_map();
      for (int c = 5; c <= 304; c++) full_map[c] = 1'b1;
      model_frame(0);
      run_frame(mdone + 3, 0, -1, -1, -1, 4'd0, 24'd0);
      gather(0, mdone + 2);
      checks++;
      if (doneq.size() != 1 || doneq[0] != mdone || stall_tr[mdone] !== 8'd255 ||
          pq.size() != NPIX || pq[1] != 306) begin
         errors++;
         $display("FAIL stall_sat: done=%0d stall=%0d pix1=%0d want %0d/255/306",
                  (doneq.size() > 0) ? doneq[0] : -1, stall_tr[mdone],
                  (pq.size() > 1) ? pq[1] : -1, mdone);
      end
   endtask

   task automatic test_start_handling();
      clear_map();
      run_frame(100, 0, 10, -1, -1, 4'd0, 24'd0);
      gather(0, 99);
      checks++;
      if (pq.size() != NPIX || doneq.size() != 1 || doneq[0] != 69) begin
         errors++; $display("FAIL start_ignored: pushes=%0d ndone=%0d want 16/1", pq.size(), doneq.size());
      end
      // start held: second frame is accepted on the first IDLE cycle
      run_frame(145, 75, -1, -1, -1, 4'd0, 24'd0);
      gather(0, 144);
      checks++;
      if (pq.size() != 2 * NPIX || pq[NPIX] != 73 || dq[NPIX] !== {pix_model[0], 8'h00}) begin
         errors++; $display("FAIL start_held: pushes=%0d second=%0d want 32/73",
                            pq.size(), (pq.size() > NPIX) ? pq[NPIX] : -1);
      end
      for (int c = 5; c <= 14; c++) full_map[c] = 1'b1;
      model_frame(80);
      run_frame(155, 85, -1, -1, -1, 4'd0, 24'd0);
      gather(0, 154);
      checks++;
      if (stall_tr[79] !== 8'd10 || stall_tr[81] !== 8'd0 || pq.size() != 2 * NPIX || pq[NPIX] != mpc[0]) begin
         errors++; $display("FAIL start_stall_clear: s79=%0d s81=%0d second=%0d want 10/0/%0d",
                            stall_tr[79], stall_tr[81], (pq.size() > NPIX) ? pq[NPIX] : -1, mpc[0]);
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      clear_map();
      run_frame(40, 0, -1, 20, -1, 4'd0, 24'd0);
      gather(0, 39);
      for (int c = 21; c < 40; c++) if (act_tr[c] !== 6'd0 || busy_tr[c] !== 1'b0) bad++;
      checks++;
      if (bad != 0 || pq.size() != 6) begin
         errors++; $display("FAIL rstmid_quiet: bad_cycles=%0d pushes=%0d want 0/6", bad, pq.size());
      end
      run_frame(75, 0, -1, -1, -1, 4'd0, 24'd0);
      gather(0, 74);
      checks++;
      if (pq.size() != NPIX || pq[0] != 3 || dq[0] !== {pix_model[0], 8'h00}) begin
         errors++; $display("FAIL rstmid_replay: n=%0d din0=%h want 16/%h",
                            pq.size(), (pq.size() > 0) ? dq[0] : 32'hx, {pix_model[0], 8'h00});
      end
   endtask

   task automatic test_write_during_frame();
      logic [23:0] old0;
      clear_map();
      run_frame(75, 0, -1, -1, 30, 4'd15, 24'hABCDEF);
      pix_model[15] = 24'hABCDEF;
      gather(0, 74);
      checks++;
      if (pq.size() != NPIX || dq[NPIX-1] !== 32'hABCDEF00) begin
         errors++; $display("FAIL wr_late_addr: last=%h want abcdef00", (pq.size() == NPIX) ? dq[NPIX-1] : 32'hx);
      end
      old0 = pix_model[0];
      run_frame(75, 0, -1, -1, 30, 4'd0, 24'h5A5A5A);
      pix_model[0] = 24'h5A5A5A;
      gather(0, 74);
      checks++;
      if (pq.size() != NPIX || dq[0] !== {old0, 8'h00}) begin
         errors++; $display("FAIL wr_early_addr: first=%h want %h", (pq.size() > 0) ? dq[0] : 32'hx, {old0, 8'h00});
      end
      // pixel 2 is read in cycle 7; a same-cycle write must not be seen
      old0 = pix_model[2];
      run_frame(75, 0, -1, -1, 7, 4'd2, 24'h123456);
      pix_model[2] = 24'h123456;
      gather(0, 74);
      checks++;
      if (pq.size() != NPIX || dq[0] !== 32'h5A5A5A00 || dq[2] !== {old0, 8'h00}) begin
         errors++; $display("FAIL wr_read_first: d0=%h d2=%h want 5a5a5a00/%h",
                            (pq.size() > 2) ? dq[0] : 32'hx, (pq.size() > 2) ? dq[2] : 32'hx, {old0, 8'h00});
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < NPIX; i++) write_pix(4'(i), 24'($urandom));
         clear_map();
         for (int c = 0; c < 400; c++) full_map[c] = ($urandom_range(0, 3) == 0);
         model_frame(0);
         run_frame(mdone + 3, 0, -1, -1, -1, 4'd0, 24'd0);
         gather(0, mdone + 2);
         checks++;
         if (pq.size() != NPIX) begin
            errors++; $display("FAIL rand%0d_count: pushes=%0d want %0d", it, pq.size(), NPIX);
         end else begin
            for (int k = 0; k < NPIX; k++) begin
               checks++;
               if (pq[k] != mpc[k] || dq[k] !== {pix_model[k], 8'h00}) begin
                  errors++; $display("FAIL rand%0d_push%0d: cyc=%0d din=%h want %0d/%h",
                                     it, k, pq[k], dq[k], mpc[k], {pix_model[k], 8'h00});
               end
            end
         end
         checks++;
         if (doneq.size() != 1 || doneq[0] != mdone || stall_tr[mdone] !== 8'(mstall) || b2b != 0) begin
            errors++; $display("FAIL rand%0d_done: cyc=%0d stall=%0d b2b=%0d want %0d/%0d/0", it,
                               (doneq.size() > 0) ? doneq[0] : -1, stall_tr[mdone], b2b, mdone, mstall);
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; tx_full = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0;
      test_reset();
      test_full_frame();
      test_backpressure();
      test_stall_saturate();
      test_start_handling();
      test_reset_mid();
      test_write_during_frame();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ws_pixel_feeder.md
# ws_pixel_feeder

Upstream feeder for the PIO-based WS2812 driver. It holds a frame of NPIX 24-bit GRB pixels in local RAM. On request it streams the frame into a PIO state machine's TX FIFO through the PIO `action`/`din` push interface, honouring `tx_full` backpressure. It then waits out the WS2812 latch gap and signals frame completion. It replaces hand-written push loops in tops.

## Interface
Parameters:
- `NPIX`, 16: pixels per frame; must be a power of two, ≤ 256.
- `LATCH_CYCLES`, 5000: clk cycles idled after the last push. Must exceed the FIFO drain time plus 50 µs; 200 µs at 25 MHz.
- `SM_INDEX`, 0: PIO state machine that receives the pushes.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: reset is synchronous and active-high.
- `wr_en` in 1: pixel RAM write strobe.
- `wr_addr` in $clog2(NPIX): pixel RAM write address.
- `wr_data` in 24: pixel value, {G,R,B}.
- `start` in 1: frame request level, sampled only in IDLE.
- `tx_full` in 1: TX-full flag of the selected SM, i.e. `tx_full[SM_INDEX]` from the PIO.
- `action` out 6: PIO action code, either 0 (NOP) or 4 (PUSH).
- `din` out 32: PIO data, {pixel, 8'h00}, left-aligned for shift-left OUT with a 24-bit pull threshold.
- `mindex` out 2: constant `SM_INDEX`.
- `busy` out 1: a frame is in progress.
- `frame_done` out 1: one-cycle pulse at frame end.
- `stall_cnt` out 8: count of PUSH-state cycles blocked by `tx_full`; saturates at 255.

## Operation
- FSM states: IDLE, READ, PUSH, GAP, LATCH, DONE.
- IDLE: on `start`=1, clear `stall_cnt` and the pixel index, then go to READ.
- READ: present the index to the RAM (synchronous read), then go to PUSH.
- PUSH:
  - If `tx_full`=0: register `action`<=4 and `din`<={rd_data,8'h00}, increment the index, go to GAP.
  - Otherwise: stay in PUSH; `stall_cnt` += 1, saturating.
- GAP: register `action`<=0. Go to LATCH if index==NPIX, else READ.
  - The mandatory gap guarantees `tx_full` reflects the previous push before the next decision.
  - `action`=4 is therefore never high in two consecutive cycles.
- LATCH: count LATCH_CYCLES cycles, then go to DONE.
- DONE: `frame_done`=1 for one cycle, then go to IDLE.
- `busy` = (state != IDLE && state != DONE).
- `start` outside IDLE is ignored. A `start` held high begins the next frame on the first IDLE cycle.
- RAM is read-first. A same-cycle write and read to the same address returns the old value. Writes during a frame are allowed: addresses not yet read are pushed with the new data.
- RAM is not cleared by reset.
- Index width is $clog2(NPIX)+1. The latch counter width is $clog2(LATCH_CYCLES+1).
- Reset values: `action`=0, `din`=0, `mindex`=SM_INDEX, `busy`=0, `frame_done`=0, `stall_cnt`=0, state IDLE.
- Reset mid-frame: `action`=0 from the next cycle on, and the partial frame is abandoned. The next `start` replays from pixel 0.

## Timing
- Reference point: `start` sampled in cycle 0, in IDLE.
- Cycle 1: `busy`=1, READ pixel 0.
- Cycle 2: PUSH.
- With no backpressure, `action`=4 is high in cycles 3+3k for k=0..NPIX-1. With NPIX=16 the last push is in cycle 48.
- Each stalled PUSH cycle adds 1 cycle to every later push.
- LATCH occupies cycles 49..48+LATCH_CYCLES.
- `frame_done`=1 and `busy`=0 in cycle 49+LATCH_CYCLES.
- The earliest next `start` is accepted in cycle 50+LATCH_CYCLES.
- `din` holds its last pushed value until the next push; only `action` qualifies it.

## Structure
- Package `ws_pkg`:
  - action codes ACT_NOP=0, ACT_INSTR=1, ACT_PUSH=4.
  - 24-bit pixel typedef.
  - FSM state enum.
- Sub-module `ws_pixel_ram`: NPIX×24 array, one write port, one synchronous read-first read port.
- Top-level instances connect `action`/`din`/`mindex` to the PIO when no other agent drives it. Otherwise the top muxes them after program and config load completes.

## Test plan
1. **Reset:** assert `reset` for 3 cycles with `start`=1 → all outputs at reset values; no push while `reset`=1.
2. **Full frame:** LATCH_CYCLES=20. Write pixel i = 24'h010203*i for i=0..15; pulse `start`; hold `tx_full`=0.
   - 16 pushes in cycles 3,6,…,48 with `din`={pix_i,8'h00}.
   - `frame_done` in cycle 69; `stall_cnt`=0.
3. **Backpressure:** as scenario 2, but `tx_full`=1 in cycles 5..14.
   - No `action`=4 in cycles 5..15.
   - Pixel 1 is pushed in cycle 16; `stall_cnt`=10; `frame_done` in cycle 79.
4. **Start handling:** `start` pulsed in cycle 10 → ignored. `start` held high continuously → second frame's first push in cycle 3+70=73, and `stall_cnt` is cleared at acceptance.
5. **Reset mid-frame:** `reset` in cycle 20.
   - `action`=0 and `busy`=0 from cycle 21.
   - A later `start` pushes pixel 0 first.
6. **Write during frame:** write 24'hABCDEF to address 15 in cycle 30 → the last push carries `din`=32'hABCDEF00. Write to address 0 in cycle 30 → visible only in the next frame.
